// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : two-port round-robin arbiter/sequencer for top_mem_sys
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_0,
   output logic              req_ready_0,
   input  logic              req_we_0,
   input  logic [2:0]        req_func3_0,
   input  logic [ADDR_W-1:0] req_addr_0,
   input  logic [DATA_W-1:0] req_wdata_0,
   input  logic              req_valid_1,
   output logic              req_ready_1,
   input  logic              req_we_1,
   input  logic [2:0]        req_func3_1,
   input  logic [ADDR_W-1:0] req_addr_1,
   input  logic [DATA_W-1:0] req_wdata_1,
   output logic              rsp_valid_0,
   output logic [DATA_W-1:0] rsp_rdata_0,
   output logic              rsp_err_0,
   output logic              rsp_valid_1,
   output logic [DATA_W-1:0] rsp_rdata_1,
   output logic              rsp_err_1,
   output logic              mem_ena,
   output logic [ADDR_W-1:0] mem_addrA,
   output logic [2:0]        mem_func3,
   output logic [DATA_W-1:0] mem_store_data,
   input  logic [DATA_W-1:0] mem_load_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic                last;
   logic                owner;
   logic                cmd_we;
   logic                cmd_err;
   logic [2:0]          cmd_func3;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [DATA_W-1:0]   rdata;

   logic                grant_0, grant_1, accept;
   logic                sel_we;
   logic [2:0]          sel_func3;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic                sel_err;

   // Illegal func3 for the direction, or a misaligned halfword/word access.
   function automatic logic cmd_illegal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
      logic bad_f3;
      bad_f3 = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      return bad_f3 | ((f3[1:0] == 2'b01) & a[0]) | ((f3 == 3'b010) & (a != 2'b00));
   endfunction

   always_comb begin
      grant_0 = 1'b0;
      grant_1 = 1'b0;
      if (state == IDLE) begin
         if (req_valid_0 && req_valid_1) begin
            grant_0 = last;
            grant_1 = ~last;
         end else begin
            grant_0 = req_valid_0;
            grant_1 = req_valid_1;
         end
      end
   end

   assign accept    = grant_0 | grant_1;
   assign sel_we    = grant_1 ? req_we_1    : req_we_0;
   assign sel_func3 = grant_1 ? req_func3_1 : req_func3_0;
   assign sel_addr  = grant_1 ? req_addr_1  : req_addr_0;
   assign sel_wdata = grant_1 ? req_wdata_1 : req_wdata_0;
   assign sel_err   = cmd_illegal(sel_we, sel_func3, sel_addr[1:0]);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 1'b1;
         owner     <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_err   <= 1'b0;
         cmd_func3 <= 3'd0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         rdata     <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            last      <= grant_1;
            owner     <= grant_1;
            cmd_we    <= sel_we;
            cmd_err   <= sel_err;
            cmd_func3 <= sel_func3;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
         end
         if (state == ACCESS)
            rdata <= (!cmd_we && !cmd_err) ? mem_load_data : '0;
      end
   end

   assign req_ready_0    = grant_0;
   assign req_ready_1    = grant_1;
   assign mem_ena        = (state == ACCESS) & cmd_we & ~cmd_err;
   assign mem_addrA      = cmd_addr;
   assign mem_func3      = cmd_func3;
   assign mem_store_data = cmd_wdata;

   assign rsp_valid_0 = (state == RESP) & ~owner;
   assign rsp_valid_1 = (state == RESP) &  owner;
   assign rsp_rdata_0 = rsp_valid_0 ? rdata : '0;
   assign rsp_rdata_1 = rsp_valid_1 ? rdata : '0;
   assign rsp_err_0   = rsp_valid_0 & cmd_err;
   assign rsp_err_1   = rsp_valid_1 & cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench with a byte-addressed memory model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid_0 = 0, req_we_0 = 0, req_valid_1 = 0, req_we_1 = 0;
   logic [2:0]  req_func3_0 = 0, req_func3_1 = 0;
   logic [5:0]  req_addr_0 = 0, req_addr_1 = 0;
   logic [31:0] req_wdata_0 = 0, req_wdata_1 = 0;
   logic        req_ready_0, req_ready_1;
   logic        rsp_valid_0, rsp_err_0, rsp_valid_1, rsp_err_1;
   logic [31:0] rsp_rdata_0, rsp_rdata_1;
   logic        mem_ena;
   logic [5:0]  mem_addrA;
   logic [2:0]  mem_func3;
   logic [31:0] mem_store_data, mem_load_data;

   mem_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
      .req_func3_0(req_func3_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
      .req_func3_1(req_func3_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
      .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
      .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
      .mem_ena(mem_ena), .mem_addrA(mem_addrA), .mem_func3(mem_func3),
      .mem_store_data(mem_store_data), .mem_load_data(mem_load_data)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Memory model: write on the rising edge, combinational extended read.
   logic [7:0] mem [64];
   logic [5:0] a1, a2, a3;
   assign a1 = mem_addrA + 6'd1;
   assign a2 = mem_addrA + 6'd2;
   assign a3 = mem_addrA + 6'd3;

   always @(posedge clk) begin
      if (mem_ena) begin
         mem[mem_addrA] <= mem_store_data[7:0];
         if (mem_func3[1:0] != 2'b00) mem[a1] <= mem_store_data[15:8];
         if (mem_func3[1:0] == 2'b10) begin
            mem[a2] <= mem_store_data[23:16];
            mem[a3] <= mem_store_data[31:24];
         end
      end
   end

   always_comb begin
      mem_load_data = 32'd0;
      case (mem_func3)
         3'b000:  mem_load_data = {{24{mem[mem_addrA][7]}}, mem[mem_addrA]};
         3'b001:  mem_load_data = {{16{mem[a1][7]}}, mem[a1], mem[mem_addrA]};
         3'b010:  mem_load_data = {mem[a3], mem[a2], mem[a1], mem[mem_addrA]};
         3'b100:  mem_load_data = {24'd0, mem[mem_addrA]};
         3'b101:  mem_load_data = {16'd0, mem[a1], mem[mem_addrA]};
         default: mem_load_data = 32'd0;
      endcase
   end

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic        exp_order[$];
   int          checks = 0, fails = 0;
   int          drv_timeouts = 0, timeouts_seen = 0;
   int          acc_cyc = -10;
   logic        acc_ena = 0;
   logic [5:0]  acc_addr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Monitor: reset state, mem_ena windows, ready blackout, responses.
   always @(negedge clk) begin
      exp_t e;
      logic p, busy;
      if (drv_timeouts != timeouts_seen) begin
         checks++;
         fails++;
         $display("FAIL timeout: %0d driver waits expired, expected 0", drv_timeouts - timeouts_seen);
         timeouts_seen = drv_timeouts;
      end
      if (!rst_n) begin
         chk("reset_outputs", {26'd0, req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
                               rsp_err_0, rsp_err_1} | rsp_rdata_0 | rsp_rdata_1, 32'd0);
         chk("reset_mem", {25'd0, mem_ena, mem_addrA} | {29'd0, mem_func3} | mem_store_data, 32'd0);
      end else begin
         chk("mem_ena", {31'd0, mem_ena}, {31'd0, (cycle == acc_cyc) && acc_ena});
         if (cycle == acc_cyc && acc_ena) chk("mem_addr", {26'd0, mem_addrA}, {26'd0, acc_addr});
         busy = (cycle == acc_cyc) || rsp_valid_0 || rsp_valid_1;
         if (busy) chk("ready_busy", {30'd0, req_ready_0, req_ready_1}, 32'd0);
         if (rsp_valid_0 || rsp_valid_1) begin
            p = rsp_valid_1;
            chk("rsp_one_hot", {31'd0, rsp_valid_0 & rsp_valid_1}, 32'd0);
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_port", {31'd0, p}, {31'd0, e.port});
               chk("rsp_rdata", p ? rsp_rdata_1 : rsp_rdata_0, e.rdata);
               chk("rsp_err", {31'd0, p ? rsp_err_1 : rsp_err_0}, {31'd0, e.err});
               chk("rsp_latency", cycle, e.cyc);
               chk("rsp_other_zero", p ? (rsp_rdata_0 | {31'd0, rsp_err_0})
                                       : (rsp_rdata_1 | {31'd0, rsp_err_1}), 32'd0);
            end
            if (exp_order.size() == 0) chk("order_extra", 32'd1, 32'd0);
            else chk("grant_order", {31'd0, p}, {31'd0, exp_order.pop_front()});
         end
      end
   end

   task automatic issue(input int p, input logic we, input logic [2:0] f3,
                        input logic [5:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
      logic acc;
      int   n;
      if (p == 0) begin
         req_valid_0 = 1; req_we_0 = we; req_func3_0 = f3; req_addr_0 = a; req_wdata_0 = wd;
      end else begin
         req_valid_1 = 1; req_we_1 = we; req_func3_1 = f3; req_addr_1 = a; req_wdata_1 = wd;
      end
      acc = 0;
      n = 0;
      while (!acc && n < 60) begin
         @(negedge clk);
         acc = (p == 0) ? req_ready_0 : req_ready_1;
         n++;
      end
      if (acc) begin
         sb.push_back('{p[0], exp_rd, exp_err, cycle + 2});
         acc_cyc  = cycle + 1;
         acc_ena  = we & ~exp_err;
         acc_addr = a;
      end else begin
         drv_timeouts++;
      end
      @(posedge clk);
      #1;
      if (p == 0) req_valid_0 = 0; else req_valid_1 = 0;
   endtask

   task automatic push_order(input int n, input logic [7:0] pat);
      for (int i = 0; i < n; i++) exp_order.push_back(pat[i]);
   endtask

   initial begin
      int n;
      #2 rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // Tie right after reset: port 0 first, then port 1 reads sign-extended byte.
      push_order(2, 8'b10);
      fork
         issue(0, 1, 3'b000, 6'd9, 32'h000000F4, 32'h0, 0);
         issue(1, 0, 3'b000, 6'd9, 32'h0, 32'hFFFFFFF4, 0);
      join

      push_order(2, 8'b00);
      issue(0, 1, 3'b010, 6'd8, 32'hAABBCCDD, 32'h0, 0);
      issue(0, 0, 3'b010, 6'd8, 32'h0, 32'hAABBCCDD, 0);

      // Port 0 went last, so the tie goes to port 1.
      push_order(2, 8'b01);
      fork
         issue(1, 0, 3'b100, 6'd9, 32'h0, 32'h000000CC, 0);
         issue(0, 0, 3'b101, 6'd10, 32'h0, 32'h0000AABB, 0);
      join
      push_order(1, 8'b1);
      issue(1, 0, 3'b010, 6'd8, 32'h0, 32'hAABBCCDD, 0);

      // Fairness with both ports streaming; byte stores assemble a word.
      push_order(6, 8'b101010);
      fork
         begin
            issue(0, 1, 3'b000, 6'd4, 32'h123456AA, 32'h0, 0);
            issue(0, 1, 3'b000, 6'd6, 32'h123456CC, 32'h0, 0);
            issue(0, 0, 3'b010, 6'd4, 32'h0, 32'hDDCCBBAA, 0);
         end
         begin
            issue(1, 1, 3'b000, 6'd5, 32'h987654BB, 32'h0, 0);
            issue(1, 1, 3'b000, 6'd7, 32'h987654DD, 32'h0, 0);
            issue(1, 0, 3'b010, 6'd8, 32'h0, 32'hAABBCCDD, 0);
         end
      join

      // Rejected commands, then memory proven untouched.
      push_order(6, 8'b011000);
      issue(0, 0, 3'b010, 6'd6, 32'h0, 32'h0, 1);
      issue(0, 1, 3'b001, 6'd11, 32'h0000FFFF, 32'h0, 1);
      issue(0, 0, 3'b011, 6'd0, 32'h0, 32'h0, 1);
      issue(1, 1, 3'b011, 6'd4, 32'hFFFFFFFF, 32'h0, 1);
      issue(1, 1, 3'b100, 6'd4, 32'hFFFFFFFF, 32'h0, 1);
      issue(0, 0, 3'b010, 6'd4, 32'h0, 32'hDDCCBBAA, 0);

      // Halfword store and zero/sign-extended reads.
      push_order(4, 8'b1001);
      issue(1, 1, 3'b001, 6'd10, 32'h1234F00D, 32'h0, 0);
      issue(0, 0, 3'b101, 6'd10, 32'h0, 32'h0000F00D, 0);
      issue(0, 0, 3'b001, 6'd10, 32'h0, 32'hFFFFF00D, 0);
      issue(1, 0, 3'b010, 6'd8, 32'h0, 32'hF00DCCDD, 0);

      // Reset during ACCESS: command from port 0 is discarded without response.
      req_valid_0 = 1; req_we_0 = 1; req_func3_0 = 3'b010; req_addr_0 = 6'd12;
      req_wdata_0 = 32'h11223344;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready_0 && n < 60);
      if (!req_ready_0) drv_timeouts++;
      @(posedge clk);
      #3 rst_n = 0;
      req_valid_0 = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1;

      // last restored to 1: tie goes to port 0 even though port 0 went last.
      push_order(2, 8'b10);
      fork
         issue(0, 0, 3'b010, 6'd8, 32'h0, 32'hF00DCCDD, 0);
         issue(1, 0, 3'b010, 6'd4, 32'h0, 32'hDDCCBBAA, 0);
      join

      n = 0;
      while ((sb.size() != 0 || exp_order.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || exp_order.size() != 0) drv_timeouts++;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
